// File: rtl/aes_inv_cipher_iter.sv
// Iterative AES-128 inverse cipher: one decryption round per clock behind a
// valid/ready handshake, with a phase sideband carried alongside the block.
//
//   state | meaning
//   IDLE  | ready for a block; o_ready high
//   ROUND | inverse rounds in progress, counter selects the round key
//   DONE  | plaintext registered on the outputs, held until i_ready
module aes_inv_cipher_iter #(
  parameter int PHASE_W = 3,
  parameter int NR      = 10
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 i_valid,
  output logic                 o_ready,
  input  logic [0:127]         i_cipher_text,
  input  logic [0:1407]        i_key_schedule,
  input  logic [0:PHASE_W-1]   i_phase,
  output logic                 o_valid,
  input  logic                 i_ready,
  output logic [0:127]         o_plain_text,
  output logic [0:PHASE_W-1]   o_phase
);

  typedef enum logic [1:0] {IDLE, ROUND, DONE} state_t;

  localparam logic [0:2047] INV_SBOX = {
    128'h52096ad53036a538bf40a39e81f3d7fb, 128'h7ce339829b2fff87348e4344c4dee9cb,
    128'h547b9432a6c2233dee4c950b42fac34e, 128'h082ea16628d924b2765ba2496d8bd125,
    128'h72f8f66486689816d4a45ccc5d65b692, 128'h6c704850fdedb9da5e154657a78d9d84,
    128'h90d8ab008cbcd30af7e45805b8b34506, 128'hd02c1e8fca3f0f02c1afbd0301138a6b,
    128'h3a9111414f67dcea97f2cfcef0b4e673, 128'h96ac7422e7ad3585e2f937e81c75df6e,
    128'h47f11a711d29c5896fb7620eaa18be1b, 128'hfc563e4bc6d279209adbc0fe78cd5af4,
    128'h1fdda8338807c731b11210592780ec5f, 128'h60517fa919b54a0d2de57a9f93c99cef,
    128'ha0e03b4dae2af5b0c8ebbb3c83539961, 128'h172b047eba77d626e169146355210c7d
  };

  function automatic logic [7:0] inv_sub(input logic [7:0] x);
    return INV_SBOX[{x, 3'b000} +: 8];
  endfunction

  function automatic logic [7:0] xt(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] mul9(input logic [7:0] a);
    return xt(xt(xt(a))) ^ a;
  endfunction

  function automatic logic [7:0] mulb(input logic [7:0] a);
    return xt(xt(xt(a))) ^ xt(a) ^ a;
  endfunction

  function automatic logic [7:0] muld(input logic [7:0] a);
    return xt(xt(xt(a))) ^ xt(xt(a)) ^ a;
  endfunction

  function automatic logic [7:0] mule(input logic [7:0] a);
    return xt(xt(xt(a))) ^ xt(xt(a)) ^ xt(a);
  endfunction

  function automatic logic [0:31] inv_mix_col(input logic [0:31] a);
    return {mule(a[0:7]) ^ mulb(a[8:15]) ^ muld(a[16:23]) ^ mul9(a[24:31]),
            mul9(a[0:7]) ^ mule(a[8:15]) ^ mulb(a[16:23]) ^ muld(a[24:31]),
            muld(a[0:7]) ^ mul9(a[8:15]) ^ mule(a[16:23]) ^ mulb(a[24:31]),
            mulb(a[0:7]) ^ muld(a[8:15]) ^ mul9(a[16:23]) ^ mule(a[24:31])};
  endfunction

  state_t               state, state_nxt;
  logic [0:127]         blk;
  logic [0:1407]        ks_q;
  logic [0:PHASE_W-1]   phase_q;
  logic [3:0]           cnt;
  logic [0:127]         rk, isr, isb, ark, imc, round_out;

  assign o_ready = (state == IDLE);
  assign rk      = ks_q[{cnt, 7'b0000000} +: 128];

  // One inverse round; the last round (counter 0) skips InvMixColumns.
  always_comb begin
    isr = '0;
    isb = '0;
    imc = '0;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        isr[8*(4*c+r) +: 8] = blk[8*(4*((c-r+4)%4)+r) +: 8];
      end
    end
    for (int b = 0; b < 16; b++) begin
      isb[8*b +: 8] = inv_sub(isr[8*b +: 8]);
    end
    ark = isb ^ rk;
    for (int c = 0; c < 4; c++) begin
      imc[32*c +: 32] = inv_mix_col(ark[32*c +: 32]);
    end
    round_out = (cnt == 4'd0) ? ark : imc;
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state logic.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (i_valid)       state_nxt = ROUND;
      ROUND:   if (cnt == 4'd0)   state_nxt = DONE;
      DONE:    if (i_ready)       state_nxt = IDLE;
      default:                    state_nxt = IDLE;
    endcase
  end

  // Datapath: capture on accept, iterate rounds, register result on the last one.
  always_ff @(posedge clk) begin
    if (rst) begin
      blk          <= '0;
      ks_q         <= '0;
      phase_q      <= '0;
      cnt          <= '0;
      o_valid      <= 1'b0;
      o_plain_text <= '0;
      o_phase      <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (i_valid) begin
            ks_q    <= i_key_schedule;
            phase_q <= i_phase;
            blk     <= i_cipher_text ^ i_key_schedule[NR*128 +: 128];
            cnt     <= 4'(NR - 1);
          end
        end
        ROUND: begin
          blk <= round_out;
          if (cnt == 4'd0) begin
            o_valid      <= 1'b1;
            o_plain_text <= round_out;
            o_phase      <= phase_q;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        DONE: begin
          if (i_ready) o_valid <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_aes_inv_cipher_iter.sv
// Bench for aes_inv_cipher_iter: directed FIPS-197 vectors, backpressure,
// reset and key-change cases, then random blocks against a forward AES model.
module tb_aes_inv_cipher_iter;
  localparam int PHASE_W = 3;
  localparam int NR      = 10;

  logic               clk = 1'b0;
  logic               rst;
  logic               i_valid;
  logic               o_ready;
  logic [0:127]       i_cipher_text;
  logic [0:1407]      i_key_schedule;
  logic [0:PHASE_W-1] i_phase;
  logic               o_valid;
  logic               i_ready;
  logic [0:127]       o_plain_text;
  logic [0:PHASE_W-1] o_phase;

  aes_inv_cipher_iter #(.PHASE_W(PHASE_W), .NR(NR)) dut (
    .clk(clk), .rst(rst), .i_valid(i_valid), .o_ready(o_ready),
    .i_cipher_text(i_cipher_text), .i_key_schedule(i_key_schedule),
    .i_phase(i_phase), .o_valid(o_valid), .i_ready(i_ready),
    .o_plain_text(o_plain_text), .o_phase(o_phase)
  );

  always #5 clk = ~clk;

  typedef struct { logic [127:0] pt; logic [2:0] ph; } exp_t;
  exp_t sb[$];
  int   n_cmp = 0;
  int   n_err = 0;

  // ---------------- forward AES reference model ----------------
  function automatic logic [7:0] xt(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x;
    p = 8'h00; x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = xt(x);
    end
    return p;
  endfunction

  function automatic logic [7:0] sbox(input logic [7:0] x);
    logic [7:0] y;
    y = 8'h01;
    for (int i = 0; i < 254; i++) y = gmul(y, x);
    if (x == 8'h00) y = 8'h00;
    return y ^ {y[6:0], y[7]} ^ {y[5:0], y[7:6]} ^ {y[4:0], y[7:5]} ^ {y[3:0], y[7:4]} ^ 8'h63;
  endfunction

  function automatic logic [0:1407] key_expand(input logic [127:0] key);
    logic [31:0]   w[44];
    logic [31:0]   t;
    logic [7:0]    rc;
    logic [0:1407] ks;
    for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
    rc = 8'h01;
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t = {t[23:0], t[31:24]};
        t = {sbox(t[31:24]), sbox(t[23:16]), sbox(t[15:8]), sbox(t[7:0])} ^ {rc, 24'h0};
        rc = xt(rc);
      end
      w[i] = w[i-4] ^ t;
    end
    for (int k = 0; k <= 10; k++) ks[128*k +: 128] = {w[4*k], w[4*k+1], w[4*k+2], w[4*k+3]};
    return ks;
  endfunction

  function automatic logic [127:0] encrypt(input logic [127:0] pt, input logic [0:1407] ks);
    logic [7:0]   s[16];
    logic [7:0]   t[16];
    logic [127:0] rk, res;
    logic [7:0]   a0, a1, a2, a3;
    rk = ks[0 +: 128];
    for (int b = 0; b < 16; b++) s[b] = pt[127-8*b -: 8] ^ rk[127-8*b -: 8];
    for (int rnd = 1; rnd <= 10; rnd++) begin
      for (int b = 0; b < 16; b++) s[b] = sbox(s[b]);
      for (int c = 0; c < 4; c++)
        for (int r = 0; r < 4; r++) t[r+4*c] = s[r+4*((c+r)%4)];
      for (int c = 0; c < 4; c++) begin
        a0 = t[4*c]; a1 = t[4*c+1]; a2 = t[4*c+2]; a3 = t[4*c+3];
        if (rnd < 10) begin
          s[4*c]   = xt(a0) ^ xt(a1) ^ a1 ^ a2 ^ a3;
          s[4*c+1] = a0 ^ xt(a1) ^ xt(a2) ^ a2 ^ a3;
          s[4*c+2] = a0 ^ a1 ^ xt(a2) ^ xt(a3) ^ a3;
          s[4*c+3] = xt(a0) ^ a0 ^ a1 ^ a2 ^ xt(a3);
        end else begin
          s[4*c] = a0; s[4*c+1] = a1; s[4*c+2] = a2; s[4*c+3] = a3;
        end
      end
      rk = ks[128*rnd +: 128];
      for (int b = 0; b < 16; b++) s[b] = s[b] ^ rk[127-8*b -: 8];
    end
    for (int b = 0; b < 16; b++) res[127-8*b -: 8] = s[b];
    return res;
  endfunction

  // ---------------- checking helpers ----------------
  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  // Present a block until accepted; the expected result is queued at acceptance.
  task automatic send(input logic [127:0] ct, input logic [0:1407] ks, input logic [2:0] ph,
                      input logic [127:0] pt, input bit rnd_rdy, output int waited);
    bit   ok;
    exp_t e;
    i_cipher_text = ct; i_key_schedule = ks; i_phase = ph; i_valid = 1'b1;
    waited = 0; ok = 1'b0;
    for (int n = 0; n < 200 && !ok; n++) begin
      @(negedge clk);
      if (o_ready) ok = 1'b1;
      else begin
        tick();
        waited++;
        if (rnd_rdy) i_ready = 1'($urandom_range(0, 1));
      end
    end
    chk("accept_timeout", 128'(ok), 128'd1);
    if (ok) begin
      e.pt = pt; e.ph = ph;
      sb.push_back(e);
    end
    tick();
    i_valid = 1'b0;
  endtask

  task automatic wait_valid(output int n);
    n = 0;
    while (!o_valid && n < 40) begin
      tick();
      n++;
    end
  endtask

  // Scoreboard monitor: every completed output transfer is popped and compared.
  always @(negedge clk) begin
    if (!rst && o_valid && i_ready) begin
      exp_t e;
      n_cmp++;
      assert (sb.size() != 0) else begin
        n_err++;
        $error("FAIL sb_unexpected: observed output %h expected no output", o_plain_text);
      end
      if (sb.size() != 0) begin
        e = sb.pop_front();
        n_cmp++;
        assert (o_plain_text === e.pt) else begin
          n_err++;
          $error("FAIL sb_plain: observed %h expected %h", o_plain_text, e.pt);
        end
        n_cmp++;
        assert (o_phase === e.ph) else begin
          n_err++;
          $error("FAIL sb_phase: observed %b expected %b", o_phase, e.ph);
        end
      end
    end
  end

  // ---------------- directed sequence ----------------
  initial begin
    logic [0:1407] ks_a, ks_z, ks_r;
    logic [127:0]  ct1, pt1, ct0, pt_r, ct_r, key_r;
    logic [2:0]    ph_r;
    bit            seen;
    int            w, n;

    if (NR != 10) $fatal(1, "FAIL nr_param: observed NR=%0d expected 10", NR);

    ct1  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    pt1  = 128'h00112233445566778899aabbccddeeff;
    ct0  = 128'h66e94bd4ef8a2c3b884cfa59ca342b2e;
    ks_a = key_expand(128'h000102030405060708090a0b0c0d0e0f);
    ks_z = key_expand(128'h0);

    rst = 1'b1; i_valid = 1'b0; i_ready = 1'b1;
    i_cipher_text = '0; i_key_schedule = '0; i_phase = '0;
    repeat (3) tick();
    chk("rst_ready", 128'(o_ready), 128'd1);
    chk("rst_valid", 128'(o_valid), 128'd0);
    chk("rst_plain", o_plain_text, 128'd0);
    chk("rst_phase", 128'(o_phase), 128'd0);
    rst = 1'b0;
    tick();

    // FIPS-197 C.1
    send(ct1, ks_a, 3'b101, pt1, 1'b0, w);
    wait_valid(n);
    chk("c1_latency", 128'(n), 128'd10);
    tick();
    chk("c1_valid_one_cycle", 128'(o_valid), 128'd0);
    chk("c1_ready_after", 128'(o_ready), 128'd1);
    chk("c1_plain_kept", o_plain_text, pt1);

    // All-zero key
    send(ct0, ks_z, 3'b010, 128'd0, 1'b0, w);
    wait_valid(n);
    chk("zero_latency", 128'(n), 128'd10);
    tick();

    // Backpressure: zero-key block held, C.1 block presented and ignored meanwhile
    i_ready = 1'b0;
    send(ct0, ks_z, 3'b001, 128'd0, 1'b0, w);
    wait_valid(n);
    chk("bp_latency", 128'(n), 128'd10);
    i_valid = 1'b1; i_cipher_text = ct1; i_key_schedule = ks_a; i_phase = 3'b110;
    for (int k = 0; k < 5; k++) begin
      chk("bp_hold_plain", o_plain_text, 128'd0);
      chk("bp_hold_phase", 128'(o_phase), 128'd1);
      chk("bp_hold_valid", 128'(o_valid), 128'd1);
      chk("bp_hold_ready", 128'(o_ready), 128'd0);
      tick();
    end
    i_ready = 1'b1;
    send(ct1, ks_a, 3'b110, pt1, 1'b0, w);
    chk("bp_accept_delay", 128'(w), 128'd1);
    wait_valid(n);
    chk("bp2_latency", 128'(n), 128'd10);
    tick();

    // Mid-operation reset
    send(ct1, ks_a, 3'b111, pt1, 1'b0, w);
    repeat (3) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    sb.delete();
    chk("midrst_ready", 128'(o_ready), 128'd1);
    chk("midrst_valid", 128'(o_valid), 128'd0);
    chk("midrst_plain", o_plain_text, 128'd0);
    seen = 1'b0;
    for (int k = 0; k < 15; k++) begin
      seen = seen | o_valid;
      tick();
    end
    chk("midrst_no_output", 128'(seen), 128'd0);

    // Reset wins over a simultaneous i_valid
    i_valid = 1'b1; i_cipher_text = ct1; i_key_schedule = ks_a; rst = 1'b1;
    tick();
    rst = 1'b0; i_valid = 1'b0;
    chk("rst_priority_ready", 128'(o_ready), 128'd1);
    send(ct1, ks_a, 3'b100, pt1, 1'b0, w);
    wait_valid(n);
    chk("postrst_latency", 128'(n), 128'd10);
    tick();

    // Key and inputs change after acceptance
    send(ct1, ks_a, 3'b011, pt1, 1'b0, w);
    i_key_schedule = '1; i_cipher_text = '1; i_phase = 3'b000;
    wait_valid(n);
    chk("keychg_latency", 128'(n), 128'd10);
    tick();

    // Random stream with valid/ready gaps
    for (int b = 0; b < 8; b++) begin
      key_r = {$urandom, $urandom, $urandom, $urandom};
      pt_r  = {$urandom, $urandom, $urandom, $urandom};
      ph_r  = 3'($urandom_range(0, 7));
      ks_r  = key_expand(key_r);
      ct_r  = encrypt(pt_r, ks_r);
      repeat ($urandom_range(0, 3)) begin
        tick();
        i_ready = 1'($urandom_range(0, 1));
      end
      send(ct_r, ks_r, ph_r, pt_r, 1'b1, w);
    end
    i_ready = 1'b1;
    for (int k = 0; k < 100 && sb.size() != 0; k++) tick();
    repeat (3) tick();
    chk("drain_empty", 128'(sb.size()), 128'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/aes_inv_cipher_iter.md
Name: aes_inv_cipher_iter

Overview:
- Iterative AES-128 inverse cipher: decrypts one 128-bit block using one round per clock.
- Consumes the 11-round-key schedule in the same 1408-bit packed format produced for the encrypt pipeline.
- Receiving-side counterpart of the encrypt pipeline stages: decryption path for the GCM datapath, and a self-check/debug decryptor.
- Sits after key expansion, behind a valid/ready handshake, with a phase sideband carried through unchanged.

Parameters:
- PHASE_W, 3, width of the phase sideband carried through alongside the block.
- NR, 10, number of AES rounds. Fixed for AES-128; any other value is unsupported and the bench errors on it.

Ports:
- clk  input  1  clock, all state updates on its rising edge.
- rst  input  1  synchronous active-high reset.
- i_valid  input  1  input block valid.
- o_ready  output  1  block can accept input.
- i_cipher_text  input  [0:127]  ciphertext block. Byte b = bits [8b:8b+7]; byte order is FIPS-197 column-major (byte 0 = s0,0, byte 1 = s1,0, ...).
- i_key_schedule  input  [0:1407]  round key k = bits [128k:128k+127], k = 0..10. Key 0 is the cipher key.
- i_phase  input  [0:PHASE_W-1]  sideband, captured with the block.
- o_valid  output  1  output block valid.
- i_ready  input  1  downstream accepts output.
- o_plain_text  output  [0:127]  decrypted block.
- o_phase  output  [0:PHASE_W-1]  captured phase.

Behaviour:
- FSM states: IDLE, ROUND, DONE. Reset drives IDLE, o_valid=0, o_plain_text=0, o_phase=0, round counter=0. o_ready is 1 after reset.
- o_ready = (state==IDLE). It is combinational from state only and never depends on i_valid.
- IDLE, i_valid=1 at cycle T:
  - key schedule and phase are latched into internal registers;
  - state register <= i_cipher_text XOR rk10;
  - counter <= 9;
  - FSM -> ROUND.
- Inputs are ignored when o_ready=0. Changes to i_key_schedule after acceptance have no effect on the block in flight.
- ROUND, counter c in 9..1: state <= InvMixColumns(AddRoundKey(InvSubBytes(InvShiftRows(state)), rk_c)); then c <= c-1.
- ROUND, c==0 (final round): state <= AddRoundKey(InvSubBytes(InvShiftRows(state)), rk0); FSM -> DONE.
- DONE: o_valid=1; o_plain_text = state register and o_phase = latched phase, both registered.
- Latency: o_valid first high at cycle T+11. Throughput: one block per 12 cycles minimum.
- Output hold: o_plain_text and o_phase stay stable while o_valid=1 and i_ready=0, for any number of cycles.
- DONE with i_ready=1: output transfer completes. Next cycle FSM -> IDLE, o_valid=0, o_plain_text keeps its last value. A new block is accepted no earlier than the cycle after the transfer.
- i_ready is ignored outside DONE.
- InvSubBytes uses the standard FIPS-197 inverse S-box, implemented as a 256-entry combinational table.
- InvShiftRows rotates row r right by r bytes.
- InvMixColumns uses the matrix coefficients {0e,0b,0d,09} over GF(2^8) with reduction polynomial 0x11b.
- rst=1 in any state, including mid-ROUND or DONE:
  - next cycle is IDLE with all outputs at reset values;
  - the in-flight block is discarded and never emitted;
  - rst has priority over i_valid in the same cycle.

Test Plan:
- FIPS-197 C.1 AES-128. Key 000102030405060708090a0b0c0d0e0f expanded to 1408 bits. i_cipher_text = 69c4e0d86a7b0430d8cdb78070b4c55a, i_phase=3'b101, i_ready=1 -> o_valid at T+11 for exactly one cycle, o_plain_text = 00112233445566778899aabbccddeeff, o_phase=3'b101.
- All-zero key, i_cipher_text = 66e94bd4ef8a2c3b884cfa59ca342b2e -> o_plain_text = 00000000000000000000000000000000 at T+11.
- Backpressure. Hold i_ready=0 for 5 cycles after o_valid rises -> o_plain_text stable, o_ready=0, a second i_valid is ignored. Raise i_ready -> o_ready=1 the cycle after the transfer, the second block is accepted only then and decrypts correctly.
- Mid-operation reset. Pulse rst at T+5 -> o_valid never rises for that block, o_ready=1 the cycle after rst. A subsequent C.1 block then produces the correct plaintext.
- Key change after acceptance. Present key A and C.1 ciphertext, switch i_key_schedule to all-ones at T+1 -> output still 00112233445566778899aabbccddeeff.
- Back-to-back. Stream 8 random blocks with random i_valid/i_ready gaps, checked against a software AES reference model -> all match, in order, with none dropped or duplicated.
